// File: rtl/digdug_hiscore_xfer.sv
// Moves high-score bytes between a host byte stream and the I/O device
// high-score RAM port, in either direction, with abort and wrap-around addressing.
module digdug_hiscore_xfer #(
    parameter int unsigned RDLAT = 1
) (
    input  logic        CL,
    input  logic        RESET_N,
    input  logic        START_LD,
    input  logic        START_SV,
    input  logic        ABORT,
    input  logic [10:0] BASE,
    input  logic [10:0] LEN,
    input  logic [7:0]  HD_IN,
    input  logic        HD_INV,
    output logic        HD_INRDY,
    output logic [7:0]  HD_OUT,
    output logic        HD_OUTV,
    input  logic        HD_OUTRDY,
    output logic [10:0] HS_ADDRESS,
    output logic [7:0]  HS_DATA_IN,
    input  logic [7:0]  HS_DATA_OUT,
    output logic        HS_WRITE,
    output logic        HS_ACCESS,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_WAIT = 3'd1;
    localparam logic [2:0] S_LD_WR   = 3'd2;
    localparam logic [2:0] S_SV_ADDR = 3'd3;
    localparam logic [2:0] S_SV_RD   = 3'd4;
    localparam logic [2:0] S_SV_OUT  = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    localparam logic [1:0] RD_LAST = 2'(RDLAT - 1);

    logic [2:0]  state_q, state_d;
    logic [10:0] base_q, base_d;
    logic [10:0] len_q, len_d;
    logic [10:0] idx_q, idx_d;
    logic [1:0]  rdcnt_q, rdcnt_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  hd_out_q, hd_out_d;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rdcnt_d  = rdcnt_q;
        wdata_d  = wdata_q;
        hd_out_d = hd_out_q;

        case (state_q)
            S_IDLE: begin
                if (START_SV || START_LD) begin
                    state_d = START_SV ? S_SV_ADDR : S_LD_WAIT;
                    base_d  = BASE;
                    len_d   = LEN;
                    idx_d   = '0;
                end
            end
            S_LD_WAIT: begin
                if (HD_INV) begin
                    wdata_d = HD_IN;
                    state_d = S_LD_WR;
                end
            end
            S_LD_WR: begin
                if (idx_q == len_q) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 11'd1;
                    state_d = S_LD_WAIT;
                end
            end
            S_SV_ADDR: begin
                rdcnt_d = '0;
                state_d = S_SV_RD;
            end
            S_SV_RD: begin
                // Address has been stable for RDLAT cycles by the last SV_RD cycle.
                if (rdcnt_q == RD_LAST) begin
                    hd_out_d = HS_DATA_OUT;
                    state_d  = S_SV_OUT;
                end else begin
                    rdcnt_d = rdcnt_q + 2'd1;
                end
            end
            S_SV_OUT: begin
                if (HD_OUTRDY) begin
                    if (idx_q == len_q) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 11'd1;
                        state_d = S_SV_ADDR;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (ABORT) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge CL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rdcnt_q  <= '0;
            wdata_q  <= '0;
            hd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rdcnt_q  <= rdcnt_d;
            wdata_q  <= wdata_d;
            hd_out_q <= hd_out_d;
        end
    end

    // 11-bit sum wraps 0x7FF -> 0x000 naturally; ABORT kills a pending write combinationally.
    assign HS_ADDRESS = base_q + idx_q;
    assign HS_DATA_IN = wdata_q;
    assign HS_WRITE   = (state_q == S_LD_WR) && !ABORT;
    assign HS_ACCESS  = (state_q != S_IDLE) && (state_q != S_FIN);
    assign BUSY       = HS_ACCESS;
    assign DONE       = (state_q == S_FIN);
    assign HD_INRDY   = (state_q == S_LD_WAIT);
    assign HD_OUTV    = (state_q == S_SV_OUT);
    assign HD_OUT     = hd_out_q;

endmodule
